// File: rtl/gsu_mem_arbiter.sv
// gsu_mem_arbiter: shares one cartridge SRAM port between SNES (top priority), GSU and MCU (round-robin).
// Define MCU_PORT_EN to let the MCU requester take part; otherwise its port is ignored and tied off.
module gsu_mem_arbiter #(
    parameter int ACCESS_CYCLES = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        SNES_REQ,
    input  logic        SNES_WE,
    input  logic [23:0] SNES_ADDR,
    input  logic [7:0]  SNES_WDATA,
    output logic [7:0]  SNES_RDATA,
    output logic        SNES_RDY,
    output logic        SNES_OVF,
    input  logic        GSU_REQ,
    input  logic        GSU_WE,
    input  logic [23:0] GSU_ADDR,
    input  logic [7:0]  GSU_WDATA,
    output logic        GSU_ACK,
    output logic [7:0]  GSU_RDATA,
    input  logic        MCU_REQ,
    input  logic        MCU_WE,
    input  logic [23:0] MCU_ADDR,
    input  logic [7:0]  MCU_WDATA,
    output logic        MCU_ACK,
    output logic [7:0]  MCU_RDATA,
    output logic [23:0] MEM_ADDR,
    output logic [7:0]  MEM_WDATA,
    input  logic [7:0]  MEM_RDATA,
    output logic        MEM_OE_N,
    output logic        MEM_WE_N,
    output logic        BUSY
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef enum logic [1:0] {OWN_SNES, OWN_GSU, OWN_MCU} owner_t;
    localparam logic [3:0] LAST = 4'(ACCESS_CYCLES - 1);
    localparam logic [3:0] WE_END = 4'(ACCESS_CYCLES - 2);

    state_t      state_q, state_d;
    owner_t      owner_q, owner_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic        rr_q, rr_d;
    logic        snes_pend_q, snes_pend_d;
    logic        snes_ovf_q, snes_ovf_d;
    logic        snes_we_q, snes_we_d;
    logic [23:0] snes_addr_q, snes_addr_d;
    logic [7:0]  snes_wdata_q, snes_wdata_d;
    logic [23:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic [7:0]  snes_rdata_q, snes_rdata_d;
    logic [7:0]  gsu_rdata_q, gsu_rdata_d;
    logic [7:0]  mcu_rdata_q, mcu_rdata_d;
    logic        mcu_req, idle, last, sample;
    logic        gnt_snes, gnt_gsu, gnt_mcu, grant;

`ifdef MCU_PORT_EN
    assign mcu_req   = MCU_REQ;
    assign MCU_ACK   = state_q == DONE && owner_q == OWN_MCU;
    assign MCU_RDATA = mcu_rdata_q;
    always_ff @(posedge CLK) rr_q <= RST ? 1'b0 : rr_d;
`else
    logic unused_mcu;
    assign mcu_req    = 1'b0;
    assign rr_q       = 1'b0;
    assign MCU_ACK    = 1'b0;
    assign MCU_RDATA  = 8'd0;
    assign unused_mcu = ^{MCU_REQ, rr_d, mcu_rdata_q};
`endif

    always_comb begin
        idle         = state_q == IDLE;
        gnt_snes     = idle && snes_pend_q;
        gnt_gsu      = idle && !snes_pend_q && GSU_REQ && (!mcu_req || !rr_q);
        gnt_mcu      = idle && !snes_pend_q && mcu_req && !gnt_gsu;
        grant        = gnt_snes || gnt_gsu || gnt_mcu;
        last         = state_q == ACCESS && cnt_q == LAST;
        sample       = last && !we_q;
        state_d      = grant ? ACCESS : last ? DONE : state_q == DONE ? IDLE : state_q;
        cnt_d        = state_q == ACCESS ? cnt_q + 4'd1 : 4'd0;
        owner_d      = gnt_snes ? OWN_SNES : gnt_gsu ? OWN_GSU : gnt_mcu ? OWN_MCU : owner_q;
        we_d         = gnt_snes ? snes_we_q : gnt_gsu ? GSU_WE : gnt_mcu ? MCU_WE : we_q;
        mem_addr_d   = gnt_snes ? snes_addr_q : gnt_gsu ? GSU_ADDR : gnt_mcu ? MCU_ADDR : mem_addr_q;
        mem_wdata_d  = gnt_snes ? snes_wdata_q : gnt_gsu ? GSU_WDATA : gnt_mcu ? MCU_WDATA : mem_wdata_q;
        rr_d         = gnt_gsu ? 1'b1 : gnt_mcu ? 1'b0 : rr_q;
        // a pulse landing on the grant edge re-arms pend for the new request
        snes_pend_d  = SNES_REQ || (snes_pend_q && !gnt_snes);
        snes_ovf_d   = snes_ovf_q || (SNES_REQ && snes_pend_q);
        snes_we_d    = SNES_REQ ? SNES_WE : snes_we_q;
        snes_addr_d  = SNES_REQ ? SNES_ADDR : snes_addr_q;
        snes_wdata_d = SNES_REQ ? SNES_WDATA : snes_wdata_q;
        snes_rdata_d = sample && owner_q == OWN_SNES ? MEM_RDATA : snes_rdata_q;
        gsu_rdata_d  = sample && owner_q == OWN_GSU ? MEM_RDATA : gsu_rdata_q;
        mcu_rdata_d  = sample && owner_q == OWN_MCU ? MEM_RDATA : mcu_rdata_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            owner_q      <= OWN_SNES;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            snes_pend_q  <= 1'b0;
            snes_ovf_q   <= 1'b0;
            snes_we_q    <= 1'b0;
            snes_addr_q  <= 24'd0;
            snes_wdata_q <= 8'd0;
            mem_addr_q   <= 24'd0;
            mem_wdata_q  <= 8'd0;
            snes_rdata_q <= 8'd0;
            gsu_rdata_q  <= 8'd0;
            mcu_rdata_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            snes_pend_q  <= snes_pend_d;
            snes_ovf_q   <= snes_ovf_d;
            snes_we_q    <= snes_we_d;
            snes_addr_q  <= snes_addr_d;
            snes_wdata_q <= snes_wdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            snes_rdata_q <= snes_rdata_d;
            gsu_rdata_q  <= gsu_rdata_d;
            mcu_rdata_q  <= mcu_rdata_d;
        end
    end

    assign MEM_ADDR   = mem_addr_q;
    assign MEM_WDATA  = mem_wdata_q;
    assign MEM_OE_N   = !(state_q == ACCESS && !we_q);
    assign MEM_WE_N   = !(state_q == ACCESS && we_q && cnt_q != 4'd0 && cnt_q <= WE_END);
    assign SNES_RDY   = state_q == DONE && owner_q == OWN_SNES;
    assign GSU_ACK    = state_q == DONE && owner_q == OWN_GSU;
    assign SNES_RDATA = snes_rdata_q;
    assign GSU_RDATA  = gsu_rdata_q;
    assign SNES_OVF   = snes_ovf_q;
    assign BUSY       = state_q != IDLE;
endmodule

// File: tb/tb_gsu_mem_arbiter.sv
// tb_gsu_mem_arbiter: directed scenarios for gsu_mem_arbiter with ACCESS_CYCLES = 4.
module tb_gsu_mem_arbiter;
    logic        CLK = 1'b0, RST = 1'b1;
    logic        SNES_REQ = 0, SNES_WE = 0, GSU_REQ = 0, GSU_WE = 0, MCU_REQ = 0, MCU_WE = 0;
    logic [23:0] SNES_ADDR = 0, GSU_ADDR = 0, MCU_ADDR = 0, MEM_ADDR;
    logic [7:0]  SNES_WDATA = 0, GSU_WDATA = 0, MCU_WDATA = 0, MEM_RDATA = 0;
    logic [7:0]  SNES_RDATA, GSU_RDATA, MCU_RDATA, MEM_WDATA;
    logic        SNES_RDY, SNES_OVF, GSU_ACK, MCU_ACK, MEM_OE_N, MEM_WE_N, BUSY;

    int checks = 0, errors = 0;
    logic [31:0] oe_v, we_v, ga_v, ma_v, rdy_v, busy_v;
    logic [23:0] addr_at [32];
    logic [7:0]  wd_at [32];
    int rd_at, snes_a_at, snes_b_at;
    logic [7:0]  rd_val;
    logic [23:0] snes_a_addr, snes_b_addr;
    logic hold_gsu, hold_mcu;

    gsu_mem_arbiter #(.ACCESS_CYCLES(4)) dut (
        .CLK(CLK), .RST(RST),
        .SNES_REQ(SNES_REQ), .SNES_WE(SNES_WE), .SNES_ADDR(SNES_ADDR), .SNES_WDATA(SNES_WDATA),
        .SNES_RDATA(SNES_RDATA), .SNES_RDY(SNES_RDY), .SNES_OVF(SNES_OVF),
        .GSU_REQ(GSU_REQ), .GSU_WE(GSU_WE), .GSU_ADDR(GSU_ADDR), .GSU_WDATA(GSU_WDATA),
        .GSU_ACK(GSU_ACK), .GSU_RDATA(GSU_RDATA),
        .MCU_REQ(MCU_REQ), .MCU_WE(MCU_WE), .MCU_ADDR(MCU_ADDR), .MCU_WDATA(MCU_WDATA),
        .MCU_ACK(MCU_ACK), .MCU_RDATA(MCU_RDATA),
        .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA),
        .MEM_OE_N(MEM_OE_N), .MEM_WE_N(MEM_WE_N), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic do_reset();
        RST = 1; SNES_REQ = 0; GSU_REQ = 0; MCU_REQ = 0; SNES_WE = 0; GSU_WE = 0; MCU_WE = 0;
        rd_at = -1; rd_val = 8'h00; snes_a_at = -1; snes_b_at = -1; hold_gsu = 0; hold_mcu = 0;
        repeat (2) @(negedge CLK);
        RST = 0;
    endtask

    // records one sample per cycle at the falling edge, index 0 = first cycle after the grant edge
    task automatic observe(input int n);
        oe_v = 0; we_v = 0; ga_v = 0; ma_v = 0; rdy_v = 0; busy_v = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            oe_v[i] = !MEM_OE_N; we_v[i] = !MEM_WE_N; ga_v[i] = GSU_ACK; ma_v[i] = MCU_ACK;
            rdy_v[i] = SNES_RDY; busy_v[i] = BUSY; addr_at[i] = MEM_ADDR; wd_at[i] = MEM_WDATA;
            MEM_RDATA = (i == rd_at) ? rd_val : ~rd_val;
            if (GSU_ACK && !hold_gsu) GSU_REQ = 0;
            if (MCU_ACK && !hold_mcu) MCU_REQ = 0;
            SNES_REQ = (i == snes_a_at) || (i == snes_b_at);
            if (i == snes_a_at) SNES_ADDR = snes_a_addr;
            if (i == snes_b_at) SNES_ADDR = snes_b_addr;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({MEM_OE_N, MEM_WE_N, BUSY} !== 3'b110) begin errors++; $display("FAIL reset_strobes got %b exp 110", {MEM_OE_N, MEM_WE_N, BUSY}); end
        checks++; if ({MEM_ADDR, MEM_WDATA} !== 32'h0) begin errors++; $display("FAIL reset_bus got %h exp 0", {MEM_ADDR, MEM_WDATA}); end
        checks++; if ({SNES_RDATA, GSU_RDATA, MCU_RDATA} !== 24'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", {SNES_RDATA, GSU_RDATA, MCU_RDATA}); end
        checks++; if ({SNES_RDY, GSU_ACK, MCU_ACK, SNES_OVF} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b exp 0000", {SNES_RDY, GSU_ACK, MCU_ACK, SNES_OVF}); end
    endtask

    task automatic test_read();
        do_reset();
        GSU_REQ = 1; GSU_WE = 0; GSU_ADDR = 24'h012345; rd_at = 3; rd_val = 8'hA5;
        observe(8);
        checks++; if (oe_v !== 32'h0F) begin errors++; $display("FAIL read_oe got %h exp 0000000f", oe_v); end
        checks++; if (we_v !== 32'h0) begin errors++; $display("FAIL read_we got %h exp 0", we_v); end
        checks++; if (ga_v !== 32'h10) begin errors++; $display("FAIL read_ack got %h exp 00000010", ga_v); end
        checks++; if (busy_v !== 32'h1F) begin errors++; $display("FAIL read_busy got %h exp 0000001f", busy_v); end
        checks++; if (addr_at[0] !== 24'h012345) begin errors++; $display("FAIL read_addr got %h exp 012345", addr_at[0]); end
        checks++; if (GSU_RDATA !== 8'hA5) begin errors++; $display("FAIL read_rdata got %h exp a5", GSU_RDATA); end
    endtask

    task automatic test_write();
        logic [31:0] ack_v;
        do_reset();
`ifdef MCU_PORT_EN
        MCU_REQ = 1; MCU_WE = 1; MCU_ADDR = 24'hE00010; MCU_WDATA = 8'h3C;
`else
        GSU_REQ = 1; GSU_WE = 1; GSU_ADDR = 24'hE00010; GSU_WDATA = 8'h3C;
`endif
        observe(8);
`ifdef MCU_PORT_EN
        ack_v = ma_v;
`else
        ack_v = ga_v;
`endif
        checks++; if (we_v !== 32'h06) begin errors++; $display("FAIL write_we got %h exp 00000006", we_v); end
        checks++; if (oe_v !== 32'h0) begin errors++; $display("FAIL write_oe got %h exp 0", oe_v); end
        checks++; if (ack_v !== 32'h10) begin errors++; $display("FAIL write_ack got %h exp 00000010", ack_v); end
        checks++; if (wd_at[1] !== 8'h3C) begin errors++; $display("FAIL write_wdata got %h exp 3c", wd_at[1]); end
        checks++; if (addr_at[2] !== 24'hE00010) begin errors++; $display("FAIL write_addr got %h exp e00010", addr_at[2]); end
    endtask

    task automatic test_priority();
        do_reset();
        GSU_REQ = 1; GSU_ADDR = 24'h000010; MCU_REQ = 1; MCU_ADDR = 24'h000020;
        hold_gsu = 1; hold_mcu = 1; snes_a_at = 7; snes_a_addr = 24'h000300;
        observe(30);
`ifdef MCU_PORT_EN
        checks++; if (ga_v !== 32'h0040_0010) begin errors++; $display("FAIL prio_gsu_acks got %h exp 00400010", ga_v); end
        checks++; if (ma_v !== 32'h1000_0400) begin errors++; $display("FAIL prio_mcu_acks got %h exp 10000400", ma_v); end
        checks++; if (addr_at[6] !== 24'h000020) begin errors++; $display("FAIL prio_mcu_addr got %h exp 000020", addr_at[6]); end
`else
        checks++; if (ga_v !== 32'h1040_0410) begin errors++; $display("FAIL prio_gsu_acks got %h exp 10400410", ga_v); end
        checks++; if (ma_v !== 32'h0) begin errors++; $display("FAIL prio_mcu_acks got %h exp 0", ma_v); end
`endif
        checks++; if (rdy_v !== 32'h0001_0000) begin errors++; $display("FAIL prio_snes_rdy got %h exp 00010000", rdy_v); end
        checks++; if (addr_at[12] !== 24'h000300) begin errors++; $display("FAIL prio_snes_addr got %h exp 000300", addr_at[12]); end
        checks++; if (SNES_OVF !== 1'b0) begin errors++; $display("FAIL prio_no_ovf got %b exp 0", SNES_OVF); end
        GSU_REQ = 0; MCU_REQ = 0;
    endtask

    task automatic test_overflow();
        do_reset();
        GSU_REQ = 1; GSU_ADDR = 24'h000050; rd_at = 9; rd_val = 8'hC3;
        snes_a_at = 1; snes_a_addr = 24'h000100; snes_b_at = 2; snes_b_addr = 24'h000200;
        observe(14);
        checks++; if (SNES_OVF !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", SNES_OVF); end
        checks++; if (rdy_v !== 32'h400) begin errors++; $display("FAIL ovf_rdy got %h exp 00000400", rdy_v); end
        checks++; if (oe_v !== 32'h3CF) begin errors++; $display("FAIL ovf_oe got %h exp 000003cf", oe_v); end
        checks++; if (addr_at[6] !== 24'h000200) begin errors++; $display("FAIL ovf_addr got %h exp 000200", addr_at[6]); end
        checks++; if (SNES_RDATA !== 8'hC3) begin errors++; $display("FAIL ovf_rdata got %h exp c3", SNES_RDATA); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        GSU_REQ = 1; GSU_WE = 0; GSU_ADDR = 24'h0ABCDE; MEM_RDATA = 8'h77;
        repeat (3) @(negedge CLK);
        checks++; if (MEM_OE_N !== 1'b0) begin errors++; $display("FAIL rstmid_active got %b exp 0", MEM_OE_N); end
        RST = 1; GSU_REQ = 0;
        @(negedge CLK);
        checks++; if ({MEM_OE_N, MEM_WE_N, BUSY, GSU_ACK} !== 4'b1100) begin errors++; $display("FAIL rstmid_strobes got %b exp 1100", {MEM_OE_N, MEM_WE_N, BUSY, GSU_ACK}); end
        checks++; if (MEM_ADDR !== 24'h0) begin errors++; $display("FAIL rstmid_addr got %h exp 0", MEM_ADDR); end
        RST = 0;
        observe(8);
        checks++; if ({ga_v, busy_v} !== 64'h0) begin errors++; $display("FAIL rstmid_no_ack got %h exp 0", {ga_v, busy_v}); end
        checks++; if (GSU_RDATA !== 8'h00) begin errors++; $display("FAIL rstmid_rdata got %h exp 00", GSU_RDATA); end
    endtask

`ifndef MCU_PORT_EN
    task automatic test_no_mcu();
        do_reset();
        MCU_REQ = 1; MCU_ADDR = 24'h00F000; hold_mcu = 1;
        GSU_REQ = 1; GSU_WE = 0; GSU_ADDR = 24'h000777; rd_at = 3; rd_val = 8'h5E;
        observe(14);
        checks++; if (ma_v !== 32'h0) begin errors++; $display("FAIL nomcu_ack got %h exp 0", ma_v); end
        checks++; if (ga_v !== 32'h10) begin errors++; $display("FAIL nomcu_gsu_ack got %h exp 00000010", ga_v); end
        checks++; if (oe_v !== 32'h0F) begin errors++; $display("FAIL nomcu_oe got %h exp 0000000f", oe_v); end
        checks++; if ({GSU_RDATA, MCU_RDATA} !== 16'h5E00) begin errors++; $display("FAIL nomcu_rdata got %h exp 5e00", {GSU_RDATA, MCU_RDATA}); end
        MCU_REQ = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_write();
        test_priority();
        test_overflow();
        test_reset_mid();
`ifndef MCU_PORT_EN
        test_no_mcu();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gsu_mem_arbiter.md
# gsu_mem_arbiter

Arbitrates the single physical cartridge SRAM port between three requesters: the SNES bus, the GSU core (ROM fetch and gamepak/save RAM), and the MCU. It sits between the address decoder, which supplies already-translated 24-bit physical addresses, and the SRAM pins. It sequences each access with a fixed-length read or write strobe. SNES accesses always win; GSU and MCU share the remaining bandwidth round-robin.

## Interface
Parameters:
- ACCESS_CYCLES, 4, length of one memory access in CLK cycles (legal 3–15).

Ports (clock and reset: one clock; reset is synchronous and active-high):
- CLK  in  1  system clock
- RST  in  1  synchronous active-high reset
- SNES_REQ  in  1  one-cycle request pulse
- SNES_WE  in  1  1 = write; sampled with SNES_REQ
- SNES_ADDR  in  24  translated physical address; sampled with SNES_REQ
- SNES_WDATA  in  8  write data; sampled with SNES_REQ
- SNES_RDATA  out  8  read data
- SNES_RDY  out  1  one-cycle completion pulse
- SNES_OVF  out  1  sticky: a SNES request was lost
- GSU_REQ, GSU_WE, GSU_ADDR[23:0], GSU_WDATA[7:0]  in  level request and its attributes
- GSU_ACK  out  1  one-cycle completion pulse
- GSU_RDATA  out  8  read data
- MCU_REQ, MCU_WE, MCU_ADDR[23:0], MCU_WDATA[7:0]  in  level request and its attributes
- MCU_ACK  out  1  one-cycle completion pulse
- MCU_RDATA  out  8  read data
- MEM_ADDR  out  24  SRAM address
- MEM_WDATA  out  8  SRAM write data
- MEM_RDATA  in  8  SRAM read data
- MEM_OE_N  out  1  active-low output enable
- MEM_WE_N  out  1  active-low write enable
- BUSY  out  1  access in progress

## Operation
- States:
  - IDLE: arbitrate, and grant in the same cycle.
  - ACCESS: cycle counter runs 0..ACCESS_CYCLES-1.
  - DONE: one cycle; emits the ACK or RDY pulse, then returns to IDLE.
- SNES_REQ sets snes_pend and latches WE, ADDR and WDATA in any state.
  - If snes_pend is already set when a new pulse arrives, the new request overwrites the latch and SNES_OVF sets.
  - SNES_OVF clears only on RST.
- Priority in IDLE:
  - snes_pend wins.
  - Otherwise GSU and MCU alternate by round-robin: an rr bit points to the requester preferred next and flips to the other after each GSU or MCU grant. After reset the GSU is preferred.
  - A sole requester is granted regardless of rr.
- GSU_REQ and MCU_REQ are levels. Attributes stay stable until the matching ACK, and the requester deasserts REQ in the ACK cycle or holds it for a back-to-back access. Dropping REQ before ACK is illegal; behaviour in that case is undefined.
- On grant, MEM_ADDR and MEM_WDATA are registered from the winner and held for the whole access.
- Read access: MEM_OE_N is low for all ACCESS_CYCLES cycles. MEM_RDATA is sampled at counter = ACCESS_CYCLES-1 into the winner's RDATA register. That register holds its value until the same requester's next read.
- Write access: MEM_OE_N stays high. MEM_WE_N is low for counter 1..ACCESS_CYCLES-2, giving one cycle of setup and one of hold.
- A grant is never preempted. A SNES pulse that arrives mid-access is served at the next IDLE.

## Timing
- Reset values:
  - MEM_OE_N = 1, MEM_WE_N = 1, MEM_ADDR = 0, MEM_WDATA = 0.
  - All RDATA = 0.
  - All ACK and RDY outputs = 0, SNES_OVF = 0, BUSY = 0.
  - State IDLE, rr preferring GSU, snes_pend = 0.
- RST asserted mid-access:
  - The access is aborted and strobes deassert on the next edge.
  - No ACK or RDY pulse is emitted, and pending requests are dropped.
- Sequence for a request seen in IDLE at edge N:
  - The ACCESS cycles occupy N+1..N+ACCESS_CYCLES.
  - The ACK or RDY pulse appears in cycle N+ACCESS_CYCLES+1, with RDATA already valid.
- A back-to-back request gets its next grant at the IDLE cycle following DONE. Minimum period is ACCESS_CYCLES+2.
- Worst-case SNES latency from pulse to RDY is 2·ACCESS_CYCLES+3 cycles.
- BUSY is high in ACCESS and DONE.

## Configuration
- MCU_PORT_EN:
  - When defined, the MCU requester takes part in arbitration as described above.
  - When undefined, the MCU inputs are ignored, MCU_ACK is tied 0 and MCU_RDATA is tied 0. The GSU is then the only non-SNES requester and rr logic is removed.

## Test plan
- Single read: GSU_REQ with GSU_ADDR = 0x012345, MEM_RDATA = 0xA5, ACCESS_CYCLES = 4. Expect MEM_OE_N low for 4 cycles, GSU_ACK one cycle later, GSU_RDATA = 0xA5.
- Single write: MCU write to 0xE00010 with data 0x3C. Expect MEM_WE_N low exactly in access cycles 1–2, MEM_WDATA = 0x3C, then MCU_ACK.
- Priority and fairness: GSU_REQ and MCU_REQ held continuously. Expect grants to alternate G, M, G, M. A SNES_REQ pulse in mid-access is served next, ahead of both.
- Overflow: two SNES_REQ pulses, to 0x000100 and then 0x000200, during one GSU access. Expect SNES_OVF = 1 and a single SNES access to 0x000200.
- Reset mid-access: RST asserted at access cycle 2. Expect strobes high on the next edge, no ACK, and all outputs at their reset values.
- Without MCU_PORT_EN: MCU_REQ held high. Expect no MCU grant, MCU_ACK = 0, and GSU service unaffected.
